// File: rtl/dcmi_receiver.sv
// rtl/dcmi_receiver.sv - DCMI capture into a FWFT byte FIFO; optional CRC-8 under DCMI_RECEIVER_CRC_EN
module dcmi_receiver #(
  parameter int ADDR_W      = 9,
  parameter int SYNC_STAGES = 2
) (
  input  logic              Clk,
  input  logic              nRst,
  input  logic [7:0]        DI,
  input  logic              DSYNC,
  input  logic              DCLK,
  input  logic              ARM,
  input  logic              CLR,
  input  logic              RD,
  output logic [7:0]        DO,
  output logic              EMPTY,
  output logic              FULL,
  output logic [ADDR_W:0]   COUNT,
  output logic              OVF,
  output logic              BUSY,
  output logic              DONE,
  output logic [7:0]        CRC
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ARMED    = 3'd1;
  localparam logic [2:0] ST_WAIT_SOF = 3'd2;
  localparam logic [2:0] ST_CAPTURE  = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  logic [SYNC_STAGES-1:0]   dclk_sync_q, dclk_sync_d;
  logic [SYNC_STAGES-1:0]   dsync_sync_q, dsync_sync_d;
  logic [8*SYNC_STAGES-1:0] di_sync_q, di_sync_d;
  logic                     dclk_prev_q, dclk_prev_d;
  logic                     dsync_prev_q, dsync_prev_d;
  logic [2:0]               state_q, state_d;
  logic [ADDR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]          count_q, count_d;
  logic                     ovf_q, ovf_d;
  logic [7:0]               do_q, do_d;
  logic [7:0]               mem_q [DEPTH];

  logic       dclk_s, dsync_s, sample, dsync_rise, dsync_fall;
  logic [7:0] di_s;
  logic       arm_ok, wr_req, wr_en, rd_en, drop, full, empty;

  // Synchronizer shift chains; the last stage of each is the synced value
  always_comb begin
    dclk_sync_d  = {dclk_sync_q[SYNC_STAGES-2:0], DCLK};
    dsync_sync_d = {dsync_sync_q[SYNC_STAGES-2:0], DSYNC};
    di_sync_d    = {di_sync_q[8*SYNC_STAGES-9:0], DI};
    dclk_prev_d  = dclk_sync_q[SYNC_STAGES-1];
    dsync_prev_d = dsync_sync_q[SYNC_STAGES-1];
  end

  assign dclk_s     = dclk_sync_q[SYNC_STAGES-1];
  assign dsync_s    = dsync_sync_q[SYNC_STAGES-1];
  assign di_s       = di_sync_q[8*SYNC_STAGES-1 -: 8];
  assign sample     = dclk_s & ~dclk_prev_q;
  assign dsync_rise = dsync_s & ~dsync_prev_q;
  assign dsync_fall = ~dsync_s & dsync_prev_q;

  // Frame FSM: only a frame whose start is seen after arming gets captured
  always_comb begin
    arm_ok  = ARM && (state_q == ST_IDLE || state_q == ST_DONE);
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (arm_ok) state_d = ST_ARMED;
      ST_ARMED:    if (!dsync_s) state_d = ST_WAIT_SOF;
      ST_WAIT_SOF: if (dsync_rise) state_d = ST_CAPTURE;
      ST_CAPTURE:  if (dsync_fall) state_d = ST_DONE;
      ST_DONE:     if (arm_ok) state_d = ST_ARMED;
      default:     state_d = ST_IDLE;
    endcase
    if (CLR) state_d = ST_IDLE;
  end

  // FIFO pointers, occupancy, overflow flag and the registered head byte
  always_comb begin
    full     = (count_q == FULL_CNT);
    empty    = (count_q == '0);
    // dsync_s is low on the cycle DSYNC falls, so a coincident sample is dropped
    wr_req   = (state_q == ST_CAPTURE) && sample && dsync_s;
    rd_en    = RD && !empty && !CLR;
    wr_en    = wr_req && (!full || rd_en) && !CLR;
    drop     = wr_req && full && !rd_en && !CLR;
    wr_ptr_d = wr_en ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (wr_en && !rd_en) count_d = count_q + (ADDR_W+1)'(1);
    if (rd_en && !wr_en) count_d = count_q - (ADDR_W+1)'(1);
    ovf_d    = ovf_q | drop;
    // New head is the incoming byte when it lands exactly at the read pointer
    if (count_d == '0) do_d = do_q;
    else if (wr_en && (wr_ptr_q == rd_ptr_d)) do_d = di_s;
    else do_d = mem_q[rd_ptr_d];
    if (CLR) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      do_d     = 8'h00;
    end
  end

  // Byte storage; no reset needed, occupancy tracking guards every read
  always_ff @(posedge Clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= di_s;
  end

  // Control and synchronizer registers
  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      dclk_sync_q  <= '0;
      dsync_sync_q <= '0;
      di_sync_q    <= '0;
      dclk_prev_q  <= 1'b0;
      dsync_prev_q <= 1'b0;
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      do_q         <= 8'h00;
    end else begin
      dclk_sync_q  <= dclk_sync_d;
      dsync_sync_q <= dsync_sync_d;
      di_sync_q    <= di_sync_d;
      dclk_prev_q  <= dclk_prev_d;
      dsync_prev_q <= dsync_prev_d;
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
      do_q         <= do_d;
    end
  end

`ifdef DCMI_RECEIVER_CRC_EN
  logic [7:0] crc_q, crc_d;

  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    return c;
  endfunction

  // CRC-8 (poly 0x07) over accepted bytes only; restarts on each new arm
  always_comb begin
    crc_d = crc_q;
    if (CLR || arm_ok) crc_d = 8'h00;
    else if (wr_en) crc_d = crc8_byte(crc_q, di_s);
  end

  // CRC register
  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) crc_q <= 8'h00;
    else crc_q <= crc_d;
  end

  assign CRC = crc_q;
`else
  assign CRC = 8'h00;
`endif

  assign DO    = do_q;
  assign EMPTY = empty;
  assign FULL  = full;
  assign COUNT = count_q;
  assign OVF   = ovf_q;
  assign BUSY  = (state_q == ST_ARMED) || (state_q == ST_WAIT_SOF) || (state_q == ST_CAPTURE);
  assign DONE  = (state_q == ST_DONE);

endmodule
